// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: FSM states, ROM word
// field positions and the note half-period table for the 2.08 MHz oscillator.
package song_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, END} state_t;

   localparam int DUR_MSB = 15;
   localparam int DUR_LSB = 12;
   localparam int N0_MSB  = 11;
   localparam int N0_LSB  = 6;
   localparam int N1_MSB  = 5;
   localparam int N1_LSB  = 0;

   localparam logic [5:0] NOTE_REST = 6'd0;

   // Index 1 is C3, one semitone per step up to D8 at index 63 (A4 = 22).
   // Each value is round(2.08 MHz / (2 * f)).
   localparam logic [12:0] NOTE_DIV [0:63] = '{
      0,
      7950, 7504, 7083, 6685, 6310, 5956, 5622, 5306, 5008, 4727, 4462, 4212,
      3975, 3752, 3541, 3343, 3155, 2978, 2811, 2653, 2504, 2364, 2231, 2106,
      1988, 1876, 1771, 1671, 1578, 1489, 1405, 1327, 1252, 1182, 1115, 1053,
       994,  938,  885,  836,  789,  744,  703,  663,  626,  591,  558,  526,
       497,  469,  443,  418,  394,  372,  351,  332,  313,  295,  279,  263,
       248,  235,  221
   };

endpackage

// File: rtl/tempo_edge.sv
// Rising-edge detector on the EFB tempo output; one-cycle tick per edge.
module tempo_edge (
   input  logic clk,
   input  logic rstn,
   input  logic tempo_i,
   output logic tick_o
);

   logic tempo_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tempo_q <= 1'b0;
      else       tempo_q <= tempo_i;
   end

   assign tick_o = tempo_i & ~tempo_q;

endmodule

// File: rtl/song_sequencer.sv
// Steps the two-voice buzzer through a song held in a synchronous ROM.
// Define SONG_SEQUENCER_LOOP_EN to repeat the song until stop.
module song_sequencer
   import song_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DIV_W  = 13
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              tempo,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [DIV_W-1:0]  div0,
   output logic [DIV_W-1:0]  div1,
   output logic [1:0]        voice_en,
   output logic              busy,
   output logic              done
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DIV_W-1:0]  div0_q, div0_d, div1_q, div1_d;
   logic [1:0]        en_q, en_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              tick;
   logic [3:0]        dur;
   logic [5:0]        n0, n1;

   function automatic logic [DIV_W-1:0] note_div(input logic [5:0] idx);
      return (idx == NOTE_REST) ? '0 : DIV_W'(NOTE_DIV[idx]);
   endfunction

   tempo_edge u_tempo_edge (
      .clk     (clk),
      .rstn    (rstn),
      .tempo_i (tempo),
      .tick_o  (tick)
   );

   assign dur = rom_data[DUR_MSB:DUR_LSB];
   assign n0  = rom_data[N0_MSB:N0_LSB];
   assign n1  = rom_data[N1_MSB:N1_LSB];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         div0_q  <= '0;
         div1_q  <= '0;
         en_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         div0_q  <= div0_d;
         div1_q  <= div1_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Outputs only change on LOAD, END or stop, so a note keeps sounding
   // while the next entry is being fetched.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      div0_d  = div0_q;
      div1_d  = div1_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               addr_d  = '0;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            if (dur == 4'd0) begin
               done_d = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
               addr_d  = '0;
               state_d = FETCH;
`else
               div0_d  = '0;
               div1_d  = '0;
               en_d    = 2'b00;
               state_d = END;
`endif
            end else begin
               div0_d  = note_div(n0);
               div1_d  = note_div(n1);
               en_d    = {n1 != NOTE_REST, n0 != NOTE_REST};
               cnt_d   = dur;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (tick) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = FETCH;
               end
            end
         end
         END:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (stop) begin
         state_d = IDLE;
         div0_d  = '0;
         div1_d  = '0;
         en_d    = 2'b00;
         done_d  = 1'b0;
      end
   end

   assign rom_addr = addr_q;
   assign div0     = div0_q;
   assign div1     = div1_q;
   assign voice_en = en_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: random songs checked against a
// note-level playback model, plus stop, reset and address-wrap scenarios.
module tb_song_sequencer;
   import song_pkg::*;

   localparam int DIV_W = 13;
`ifdef SONG_SEQUENCER_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              tempo = 1'b0;
   logic              start = 1'b0, stop = 1'b0, start2 = 1'b0, stop2 = 1'b0;
   logic [7:0]        rom_addr;
   logic [1:0]        rom_addr2;
   logic [15:0]       rom_data, rom_data2;
   logic [DIV_W-1:0]  div0, div1, div0b, div1b;
   logic [1:0]        voice_en, voice_en2;
   logic              busy, done, busy2, done2;
   logic [15:0]       rom  [0:255];
   logic [15:0]       rom2 [0:3];
   logic [37:0]       obs;
   logic [31:0]       obs2;
   int                vectors = 0;
   int                miscompares = 0;

   always #5 clk = ~clk;

   // Synchronous song ROMs: data follows the address by one cycle
   always @(posedge clk) rom_data  <= rom[rom_addr];
   always @(posedge clk) rom_data2 <= rom2[rom_addr2];

   assign obs  = {div0, div1, voice_en, busy, done, rom_addr};
   assign obs2 = {div0b, div1b, voice_en2, busy2, done2, rom_addr2};

   song_sequencer #(.ADDR_W(8), .DIV_W(DIV_W)) u_dut (
      .clk(clk), .rstn(rstn), .tempo(tempo), .start(start), .stop(stop),
      .rom_addr(rom_addr), .rom_data(rom_data), .div0(div0), .div1(div1),
      .voice_en(voice_en), .busy(busy), .done(done)
   );

   song_sequencer #(.ADDR_W(2), .DIV_W(DIV_W)) u_dut2 (
      .clk(clk), .rstn(rstn), .tempo(tempo), .start(start2), .stop(stop2),
      .rom_addr(rom_addr2), .rom_data(rom_data2), .div0(div0b), .div1(div1b),
      .voice_en(voice_en2), .busy(busy2), .done(done2)
   );

   function automatic logic [15:0] entry(input int d, input int n0, input int n1);
      return {4'(d), 6'(n0), 6'(n1)};
   endfunction

   function automatic logic [DIV_W-1:0] pitch(input logic [5:0] n);
      return (n == 6'd0) ? '0 : NOTE_DIV[n];
   endfunction

   function automatic logic [1:0] voices(input logic [15:0] w);
      return {w[5:0] != 6'd0, w[11:6] != 6'd0};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      step();
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs, 38'd0);
      end
      vectors++;
      if (obs2 !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state_dut2: got %h expected %h", obs2, 32'd0);
      end
      rstn = 1'b1;
      step();
      step();
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL idle_after_reset: got %h expected %h", obs, 38'd0);
      end
   endtask

   // Plays rom[0..n-1] (end marker at rom[n]) with randomly spaced ticks
   task automatic test_play_song(input string tag, input int n);
      logic [37:0]      exp;
      logic [DIV_W-1:0] e0, e1;
      logic [1:0]       een;
      int               passes;
      passes = LOOP ? 2 : 1;
      e0 = '0; e1 = '0; een = 2'b00;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      exp = {e0, e1, een, 2'b10, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s pre_sound: got %h expected %h", tag, obs, exp);
      end
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < n; i++) begin
            e0  = pitch(rom[i][11:6]);
            e1  = pitch(rom[i][5:0]);
            een = voices(rom[i]);
            exp = {e0, e1, een, 2'b10, 8'(i)};
            step();
            vectors++;
            if (obs !== exp) begin
               miscompares++;
               $display("[TB] FAIL %s onset%0d: got %h expected %h", tag, i, obs, exp);
            end
            for (int k = 1; k <= int'(rom[i][15:12]); k++) begin
               repeat ($urandom_range(1, 4)) step();
               vectors++;
               if (obs !== exp) begin
                  miscompares++;
                  $display("[TB] FAIL %s hold%0d: got %h expected %h", tag, i, obs, exp);
               end
               tempo = 1'b1;
               step();
               tempo = 1'b0;
            end
            exp = {e0, e1, een, 2'b10, 8'(i + 1)};
            vectors++;
            if (obs !== exp) begin
               miscompares++;
               $display("[TB] FAIL %s advance%0d: got %h expected %h", tag, i, obs, exp);
            end
            step();
            vectors++;
            if (obs !== exp) begin
               miscompares++;
               $display("[TB] FAIL %s gap%0d: got %h expected %h", tag, i, obs, exp);
            end
         end
         step();
         exp = LOOP ? {e0, e1, een, 2'b11, 8'd0} : {26'd0, 2'b00, 2'b11, 8'(n)};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s end_marker: got %h expected %h", tag, obs, exp);
         end
         if (p == passes - 1) begin
            stop = LOOP;
            step();
            stop = 1'b0;
            exp = {26'd0, 2'b00, 2'b00, LOOP ? 8'd0 : 8'(n)};
            vectors++;
            if (obs !== exp) begin
               miscompares++;
               $display("[TB] FAIL %s finish: got %h expected %h", tag, obs, exp);
            end
         end else begin
            step();
         end
      end
   endtask

   task automatic test_basic_play();
      rom[0] = entry(2, 22, 0);
      rom[1] = entry(0, 0, 0);
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      vectors++;
      if ({div0, voice_en} !== {13'd2364, 2'b01}) begin
         miscompares++;
         $display("[TB] FAIL basic_a4: got %h/%b expected %h/%b", div0, voice_en, 13'd2364, 2'b01);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      test_play_song("basic", 1);
   endtask

   task automatic test_rest_voices();
      rom[0] = entry(1, 0, $urandom_range(1, 63));
      rom[1] = entry(2, $urandom_range(1, 63), $urandom_range(1, 63));
      rom[2] = entry(0, 0, 0);
      test_play_song("rest_voices", 2);
   endtask

   task automatic test_random_songs();
      int n;
      for (int s = 0; s < 3; s++) begin
         n = $urandom_range(2, 5);
         for (int i = 0; i < n; i++)
            rom[i] = entry($urandom_range(1, 3), $urandom_range(0, 63), $urandom_range(0, 63));
         rom[n] = entry(0, $urandom_range(0, 63), $urandom_range(0, 63));
         test_play_song("random", n);
      end
   endtask

   task automatic test_stop_mid_note();
      logic [37:0] exp;
      rom[0] = entry(3, $urandom_range(1, 63), $urandom_range(1, 63));
      rom[1] = entry(0, 0, 0);
      exp = {pitch(rom[0][11:6]), pitch(rom[0][5:0]), 2'b11, 2'b10, 8'd0};
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      tempo = 1'b1;
      step();
      tempo = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL start_while_busy: got %h expected %h", obs, exp);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL stop_clears: got %h expected %h", obs, 38'd0);
      end
      step();
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL stop_no_done: got %h expected %h", obs, 38'd0);
      end
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL stop_beats_start: got %h expected %h", obs, 38'd0);
      end
      step();
      step();
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL stays_idle: got %h expected %h", obs, 38'd0);
      end
   endtask

   task automatic test_reset_mid_song();
      logic [37:0] exp;
      rom[0] = entry(1, $urandom_range(0, 63), $urandom_range(0, 63));
      rom[1] = entry(2, $urandom_range(1, 63), $urandom_range(1, 63));
      rom[2] = entry(0, 0, 0);
      exp = {pitch(rom[1][11:6]), pitch(rom[1][5:0]), 2'b11, 2'b10, 8'd1};
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      tempo = 1'b1;
      step();
      tempo = 1'b0;
      step();
      step();
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL second_entry: got %h expected %h", obs, exp);
      end
      #2 rstn = 1'b0;
      #1;
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got %h expected %h", obs, 38'd0);
      end
      step();
      rstn = 1'b1;
      step();
      step();
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL no_resume: got %h expected %h", obs, 38'd0);
      end
   endtask

   task automatic test_addr_wrap();
      logic [31:0] exp;
      int          idx;
      for (int j = 0; j < 4; j++)
         rom2[j] = entry(1, $urandom_range(1, 63), $urandom_range(0, 63));
      step();
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      step();
      for (int e = 0; e < 6; e++) begin
         idx = e % 4;
         exp = {pitch(rom2[idx][11:6]), pitch(rom2[idx][5:0]), voices(rom2[idx]), 2'b10, 2'(idx)};
         step();
         vectors++;
         if (obs2 !== exp) begin
            miscompares++;
            $display("[TB] FAIL wrap_onset%0d: got %h expected %h", e, obs2, exp);
         end
         repeat ($urandom_range(1, 3)) step();
         tempo = 1'b1;
         step();
         tempo = 1'b0;
         exp[1:0] = 2'(idx + 1);
         vectors++;
         if (obs2 !== exp) begin
            miscompares++;
            $display("[TB] FAIL wrap_advance%0d: got %h expected %h", e, obs2, exp);
         end
         step();
      end
      stop2 = 1'b1;
      step();
      stop2 = 1'b0;
      vectors++;
      if (obs2 !== {30'd0, 2'd2}) begin
         miscompares++;
         $display("[TB] FAIL wrap_stop: got %h expected %h", obs2, {30'd0, 2'd2});
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'd0;
      for (int i = 0; i < 4; i++) rom2[i] = 16'd0;
      test_reset();
      test_basic_play();
      test_rest_voices();
      test_random_songs();
      test_stop_mid_note();
      test_reset_mid_song();
      test_addr_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
